// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch and load/store, with load/store
// priority and bounded fetch starvation. Optional WAIT timeout under MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_stall,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_stall,
  output logic              o_ls_valid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic       OwnFetch  = 1'b0;
  localparam logic       OwnLs     = 1'b1;
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e            r_state;
  logic              r_owner;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_valid;
  logic              r_ls_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_err;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  logic [WaitW-1:0] r_wait_cnt;
`endif

  logic w_grant_fetch;

  // Fetch wins only when alone or once it has lost STARVE_MAX arbitrations in a row.
  assign w_grant_fetch = i_if_req & (~i_ls_req | (r_starve_cnt == StarveMax));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_owner      <= OwnFetch;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_valid   <= 1'b0;
      r_ls_valid   <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
      r_err        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_mem_en   <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_if_req || i_ls_req) begin
            r_state  <= StIssue;
            r_mem_en <= 1'b1;
            if (w_grant_fetch) begin
              r_owner      <= OwnFetch;
              r_mem_addr   <= i_if_addr;
              r_mem_we     <= 1'b0;
              r_starve_cnt <= '0;
            end else begin
              r_owner     <= OwnLs;
              r_mem_addr  <= i_ls_addr;
              r_mem_we    <= i_ls_we;
              r_mem_wdata <= i_ls_wdata;
              if (i_if_req && r_starve_cnt != StarveMax) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
            end
          end
        end
        StIssue: begin
          r_state <= StWait;
`ifdef MEM_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        StWait: begin
          if (i_mem_ack) begin
            r_state <= StResp;
            if (r_owner == OwnFetch) begin
              r_if_rdata <= i_mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_mem_we) r_ls_rdata <= i_mem_rdata;
              r_ls_valid <= 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (r_wait_cnt == WaitW'(TIMEOUT - 1)) begin
            // Abort: complete the owner with zero data and flag the error.
            r_state <= StResp;
            r_err   <= 1'b1;
            if (r_owner == OwnFetch) begin
              r_if_rdata <= '0;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_mem_we) r_ls_rdata <= '0;
              r_ls_valid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
`endif
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_if_stall  = i_if_req & ~r_if_valid;
  assign o_ls_stall  = i_ls_req & ~r_ls_valid;
  assign o_if_valid  = r_if_valid;
  assign o_ls_valid  = r_ls_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_err       = r_err;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 12-bit-address, 16-bit-data memory port between the instruction fetch stage and the load/store stage of the Thumb pipeline. It uses fixed priority with anti-starvation: load/store wins by default, and fetch is forced through after a bounded number of lost arbitrations. It sequences each access as a request/strobe/acknowledge transaction and routes read data and completion back to the owner. Each requester sees a combinational stall, in the same style as the fetch stage's `stall_memory`.

## Interface
- `ADDR_W`, 12, memory word-address width.
- `DATA_W`, 16, memory data width.
- `STARVE_MAX`, 4, lost fetch arbitrations tolerated before fetch is forced (range 1..15).
- `TIMEOUT`, 64, WAIT cycles before abort (used only with `MEM_ARB_TIMEOUT_EN`).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in ADDR_W: fetch address; stable while `if_req` is high.
- `if_stall` out 1: `if_req & ~if_valid`, combinational.
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out DATA_W: fetched instruction; holds until the next fetch completion.
- `ls_req` in 1: load/store request; held until `ls_valid`.
- `ls_we` in 1: 1 = write, 0 = read.
- `ls_addr` in ADDR_W: load/store address.
- `ls_wdata` in DATA_W: write data.
- `ls_stall` out 1: `ls_req & ~ls_valid`, combinational.
- `ls_valid` out 1: one-cycle completion pulse for load/store.
- `ls_rdata` out DATA_W: load data; updated on read completions only.
- `mem_en` out 1: one-cycle access strobe.
- `mem_we` out 1: write qualifier, valid with `mem_en`.
- `mem_addr` out ADDR_W: registered address, held from ISSUE through WAIT.
- `mem_wdata` out DATA_W: registered write data.
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse from memory. It arrives at least one cycle after `mem_en`.
- `err` out 1: one-cycle timeout pulse. Tied to 0 without the macro.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. `owner` register: FETCH or LS.
- IDLE: if any request is present, select a winner, latch addr/we/wdata into the `mem_*` registers, and go to ISSUE. Stay in IDLE if there is no request.
- Winner selection:
  - `ls_req` alone → LS.
  - `if_req` alone → FETCH.
  - Both requesting → LS, unless `starve_cnt == STARVE_MAX`, in which case FETCH wins.
- Fetch writes are impossible; `mem_we` = `ls_we` only when LS is the owner, 0 otherwise.
- `starve_cnt`: increments when fetch requests and loses; clears when fetch is granted; saturates at `STARVE_MAX`.
- ISSUE: `mem_en` = 1 for exactly this cycle, then go to WAIT. A `mem_ack` seen in ISSUE is ignored.
- WAIT: on `mem_ack`, capture `mem_rdata` into the owner's rdata register and go to RESP. The capture is skipped for LS writes.
- RESP: owner's `valid` = 1; requests are not sampled. Next state is IDLE.
- `mem_ack` in IDLE or RESP is ignored.
- Reset (any state, including mid-WAIT):
  - State → IDLE; `starve_cnt` → 0.
  - `mem_en`, `mem_we`, `if_valid`, `ls_valid`, `err` → 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `ls_rdata` → 0.
  - A late ack after reset is dropped.

## Timing
- Request sampled in IDLE at cycle 0 → `mem_en` at cycle 1 → earliest `mem_ack` at cycle 2 → `valid` at cycle 3 → IDLE at cycle 4.
- Minimum 4 cycles per access; each additional memory wait cycle adds 1.
- The requester may drop or change `req`/addr in the cycle after `valid`. Back-to-back requests are re-arbitrated in IDLE.
- Worst-case fetch wait under continuous LS traffic: `STARVE_MAX` LS accesses, then the fetch access.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs in WAIT.
  - After `TIMEOUT` WAIT cycles without `mem_ack`, go to RESP with owner rdata = 0 and `err` = 1 in the RESP cycle.
  - A subsequent late ack is ignored.
- Not defined: no counter; WAIT persists until `mem_ack`; `err` is constant 0.

## Test plan
- Single fetch: `if_req`, `if_addr`=0x010 at cycle 0 → `mem_en`=1, `mem_addr`=0x010, `mem_we`=0 at cycle 1. Drive `mem_ack`, `mem_rdata`=0xB510 at cycle 2 → `if_valid`=1, `if_rdata`=0xB510 at cycle 3, `if_stall`=0 in that cycle.
- Simultaneous requests: `if_req`(0x020) and `ls_req` read(0x400) at cycle 0 → LS access first, `ls_valid` at cycle 3. Fetch is then granted in IDLE at cycle 4, `mem_addr`=0x020 at cycle 5.
- Starvation (`STARVE_MAX`=4): `ls_req` and `if_req` held continuously → four LS accesses, then the 5th grant goes to fetch. `starve_cnt` = 0 after that grant.
- Write: `ls_we`=1, `ls_addr`=0x7FE, `ls_wdata`=0x1234 → `mem_en`=1, `mem_we`=1, `mem_wdata`=0x1234. After `mem_ack`, `ls_valid` pulses and `ls_rdata` is unchanged.
- Reset in WAIT: assert `reset` two cycles after `mem_en`, then deassert and drive `mem_ack` → all outputs 0, state IDLE, no `valid`.
- Timeout (macro on, `TIMEOUT`=8): withhold `mem_ack` → after 8 WAIT cycles, `err` and `if_valid` pulse together with `if_rdata`=0. With the macro off, the FSM stays in WAIT indefinitely.
